// File: rtl/dfr_phase_sequencer_if.sv
// Control/handshake bundle between the config block, the phase sequencer
// and the reservoir datapath.
interface dfr_phase_sequencer_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 start;
    logic [CNT_WIDTH-1:0] num_init_samples;
    logic [CNT_WIDTH-1:0] num_train_samples;
    logic [CNT_WIDTH-1:0] num_test_samples;
    logic [CNT_WIDTH-1:0] num_steps_per_sample;
    logic                 step_ack;
    logic                 busy;
    logic [1:0]           phase;
    logic                 step_req;
    logic [CNT_WIDTH-1:0] sample_idx;
    logic [CNT_WIDTH-1:0] step_idx;
    logic                 sample_done;
    logic                 done;

    modport master (
        input  start, num_init_samples, num_train_samples, num_test_samples,
               num_steps_per_sample, step_ack,
        output busy, phase, step_req, sample_idx, step_idx, sample_done, done
    );

    modport slave (
        output start, num_init_samples, num_train_samples, num_test_samples,
               num_steps_per_sample, step_ack,
        input  busy, phase, step_req, sample_idx, step_idx, sample_done, done
    );
endinterface

// File: rtl/dfr_phase_sequencer.sv
// Steps the DFR datapath through INIT, TRAIN and TEST, issuing one req/ack
// handshake per reservoir step. Outputs are registered except step_req.
module dfr_phase_sequencer #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  Local_Reset,
    dfr_phase_sequencer_if.master bus
);
    typedef enum logic [2:0] {StIdle, StLoad, StInit, StTrain, StTest, StDone} state_e;

    state_e state_q, state_d;
    state_e first_phase, after_init, after_train, next_phase;

    logic [CNT_WIDTH-1:0] init_q, train_q, test_q, steps_q;
    logic [CNT_WIDTH-1:0] sample_idx_q, sample_idx_d, step_idx_q, step_idx_d;
    logic [CNT_WIDTH-1:0] cur_samples;
    logic                 busy_q, busy_d, sample_done_q, sample_done_d, done_q, done_d;
    logic [1:0]           phase_q, phase_d;
    logic                 in_phase, step_fire, last_step, last_sample;

    assign in_phase    = (state_q == StInit) || (state_q == StTrain) || (state_q == StTest);
    assign step_fire   = in_phase && bus.step_ack;

    // Only evaluated inside a phase, where both counts are known nonzero.
    assign last_step   = (step_idx_q == steps_q - CNT_WIDTH'(1));
    assign last_sample = (sample_idx_q == cur_samples - CNT_WIDTH'(1));

    assign after_train = (test_q != '0) ? StTest : StDone;
    assign after_init  = (train_q != '0) ? StTrain : after_train;
    assign first_phase = (steps_q == '0) ? StDone :
                         (init_q != '0)  ? StInit : after_init;

    always_comb begin
        cur_samples = '0;
        next_phase  = StDone;
        case (state_q)
            StInit: begin
                cur_samples = init_q;
                next_phase  = after_init;
            end
            StTrain: begin
                cur_samples = train_q;
                next_phase  = after_train;
            end
            StTest: begin
                cur_samples = test_q;
                next_phase  = StDone;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        sample_idx_d  = sample_idx_q;
        step_idx_d    = step_idx_q;
        sample_done_d = 1'b0;
        case (state_q)
            StIdle: begin
                sample_idx_d = '0;
                step_idx_d   = '0;
                if (bus.start) state_d = StLoad;
            end
            StLoad: state_d = first_phase;
            StInit, StTrain, StTest: begin
                if (step_fire) begin
                    if (!last_step) begin
                        step_idx_d = step_idx_q + CNT_WIDTH'(1);
                    end else begin
                        step_idx_d    = '0;
                        sample_done_d = 1'b1;
                        if (!last_sample) begin
                            sample_idx_d = sample_idx_q + CNT_WIDTH'(1);
                        end else begin
                            sample_idx_d = '0;
                            state_d      = next_phase;
                        end
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Registered outputs track the state being entered.
        busy_d = (state_d == StLoad) || (state_d == StInit) ||
                 (state_d == StTrain) || (state_d == StTest);
        done_d = (state_d == StDone);
        case (state_d)
            StInit:  phase_d = 2'd1;
            StTrain: phase_d = 2'd2;
            StTest:  phase_d = 2'd3;
            default: phase_d = 2'd0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
        if (Local_Reset) begin
            state_q       <= StIdle;
            sample_idx_q  <= '0;
            step_idx_q    <= '0;
            sample_done_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            phase_q       <= 2'd0;
        end else begin
            state_q       <= state_d;
            sample_idx_q  <= sample_idx_d;
            step_idx_q    <= step_idx_d;
            sample_done_q <= sample_done_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            phase_q       <= phase_d;
        end
    end

    // Counts are captured only on an accepted start; later writes cannot disturb a run.
    always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
        if (Local_Reset) begin
            init_q  <= '0;
            train_q <= '0;
            test_q  <= '0;
            steps_q <= '0;
        end else if (state_q == StIdle && bus.start) begin
            init_q  <= bus.num_init_samples;
            train_q <= bus.num_train_samples;
            test_q  <= bus.num_test_samples;
            steps_q <= bus.num_steps_per_sample;
        end
    end

    assign bus.step_req    = in_phase;
    assign bus.busy        = busy_q;
    assign bus.phase       = phase_q;
    assign bus.sample_idx  = sample_idx_q;
    assign bus.step_idx    = step_idx_q;
    assign bus.sample_done = sample_done_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_dfr_phase_sequencer.sv
// Self-checking bench: table of run configurations plus randomized runs, each
// checked cycle by cycle against an expected list of (phase, sample, step) events.
module tb_dfr_phase_sequencer;
    logic S_AXI_ACLK = 1'b0;
    logic Local_Reset;

    dfr_phase_sequencer_if #(.CNT_WIDTH(32)) bus ();

    dfr_phase_sequencer #(.CNT_WIDTH(32)) dut (
        .S_AXI_ACLK  (S_AXI_ACLK),
        .Local_Reset (Local_Reset),
        .bus         (bus)
    );

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    typedef struct {
        int unsigned ph;
        int unsigned smp;
        int unsigned stp;
    } ev_t;

    typedef struct {
        int unsigned init_n, train_n, test_n, steps;
        int unsigned ack_mode;  // 0 held high, 1 random, 2 three idle cycles between acks
        bit          disturb;   // second start + train rewrite during the run
        int unsigned exp_acks, exp_sd, exp_ph1, exp_ph2, exp_ph3;
        int unsigned exp_done_cyc;  // 0 = not checked
    } vec_t;

    int checks = 0;
    int errors = 0;

    int unsigned r_acks, r_sd, r_done_cyc;
    int unsigned r_ph [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Applies one run and checks every cycle against the event list derived from the counts.
    task automatic run(input int unsigned init_n, input int unsigned train_n,
                       input int unsigned test_n, input int unsigned steps,
                       input int unsigned ack_mode, input bit disturb);
        ev_t         q[$];
        ev_t         e;
        int unsigned cnt [4];
        int unsigned cyc;
        int unsigned gap;
        bit          exp_sd;
        bit          ack;
        bit          finished;
        cnt[1] = init_n; cnt[2] = train_n; cnt[3] = test_n; cnt[0] = 0;
        if (steps != 0) begin
            for (int p = 1; p <= 3; p++)
                for (int s = 0; s < int'(cnt[p]); s++)
                    for (int t = 0; t < int'(steps); t++) begin
                        e.ph = p; e.smp = s; e.stp = t;
                        q.push_back(e);
                    end
        end
        r_acks = 0; r_sd = 0; r_done_cyc = 0;
        for (int p = 0; p < 4; p++) r_ph[p] = 0;

        @(negedge S_AXI_ACLK);
        bus.num_init_samples     = init_n;
        bus.num_train_samples    = train_n;
        bus.num_test_samples     = test_n;
        bus.num_steps_per_sample = steps;
        bus.start                = 1'b1;
        bus.step_ack             = (ack_mode == 0);
        @(negedge S_AXI_ACLK);
        bus.start = 1'b0;
        chk("load_busy", bus.busy, 1);
        chk("load_req", bus.step_req, 0);
        chk("load_phase", bus.phase, 0);
        chk("load_done", bus.done, 0);

        cyc = 1; gap = 0; exp_sd = 0; finished = 0;
        while (!finished && cyc < 2000) begin
            @(negedge S_AXI_ACLK);
            cyc++;
            bus.start = 1'b0;
            r_sd += bus.sample_done;
            if (q.size() != 0) begin
                e = q[0];
                chk("req", bus.step_req, 1);
                chk("busy", bus.busy, 1);
                chk("done_mid", bus.done, 0);
                chk("phase", bus.phase, e.ph);
                chk("sample_idx", bus.sample_idx, e.smp);
                chk("step_idx", bus.step_idx, e.stp);
                chk("sample_done", bus.sample_done, exp_sd);
                case (ack_mode)
                    0:       ack = 1'b1;
                    1:       ack = 1'($urandom_range(0, 1));
                    default: begin
                        ack = (gap == 3);
                        gap = ack ? 0 : gap + 1;
                    end
                endcase
                bus.step_ack = ack;
                exp_sd = 1'b0;
                if (ack) begin
                    void'(q.pop_front());
                    r_acks++;
                    r_ph[e.ph]++;
                    exp_sd = (e.stp == steps - 1);
                end
                if (disturb && cyc == 3) begin
                    bus.start             = 1'b1;
                    bus.num_train_samples = 9;
                end
            end else begin
                chk("done", bus.done, 1);
                chk("done_busy", bus.busy, 0);
                chk("done_phase", bus.phase, 0);
                chk("done_req", bus.step_req, 0);
                chk("done_sd", bus.sample_done, exp_sd);
                r_done_cyc = cyc;
                finished = 1;
            end
        end
        if (!finished) chk("run_timeout", 0, 1);
        bus.step_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge S_AXI_ACLK);
            chk("idle_busy", bus.busy, 0);
            chk("idle_done", bus.done, 0);
            chk("idle_sd", bus.sample_done, 0);
        end
    endtask

    vec_t vecs [8];

    task automatic check_row(input int i);
        run(vecs[i].init_n, vecs[i].train_n, vecs[i].test_n, vecs[i].steps,
            vecs[i].ack_mode, vecs[i].disturb);
        chk($sformatf("row%0d_acks", i), r_acks, vecs[i].exp_acks);
        chk($sformatf("row%0d_sd", i), r_sd, vecs[i].exp_sd);
        chk($sformatf("row%0d_ph1", i), r_ph[1], vecs[i].exp_ph1);
        chk($sformatf("row%0d_ph2", i), r_ph[2], vecs[i].exp_ph2);
        chk($sformatf("row%0d_ph3", i), r_ph[3], vecs[i].exp_ph3);
        if (vecs[i].exp_done_cyc != 0)
            chk($sformatf("row%0d_done_cyc", i), r_done_cyc, vecs[i].exp_done_cyc);
    endtask

    initial begin
        bit found;
        //          init train test steps mode dist acks sd ph1 ph2 ph3 done_cyc
        vecs[0] = '{2, 3, 1, 4, 0, 0, 24, 6, 8, 12, 4, 26};
        vecs[1] = '{0, 2, 0, 3, 0, 0,  6, 2, 0,  6, 0,  8};
        vecs[2] = '{5, 7, 2, 0, 0, 0,  0, 0, 0,  0, 0,  2};
        vecs[3] = '{1, 1, 1, 2, 2, 0,  6, 3, 2,  2, 2, 26};
        vecs[4] = '{2, 1, 1, 2, 0, 1,  8, 4, 4,  2, 2, 10};
        vecs[5] = '{0, 0, 0, 3, 0, 0,  0, 0, 0,  0, 0,  2};
        vecs[6] = '{0, 0, 2, 1, 1, 0,  2, 2, 0,  0, 2,  0};
        vecs[7] = '{1, 0, 3, 1, 0, 0,  4, 4, 1,  0, 3,  6};

        Local_Reset              = 1'b1;
        bus.start                = 1'b0;
        bus.step_ack             = 1'b0;
        bus.num_init_samples     = '0;
        bus.num_train_samples    = '0;
        bus.num_test_samples     = '0;
        bus.num_steps_per_sample = '0;
        repeat (2) @(negedge S_AXI_ACLK);
        chk("rst_busy", bus.busy, 0);
        chk("rst_phase", bus.phase, 0);
        chk("rst_req", bus.step_req, 0);
        chk("rst_sample_idx", bus.sample_idx, 0);
        chk("rst_step_idx", bus.step_idx, 0);
        chk("rst_sd", bus.sample_done, 0);
        chk("rst_done", bus.done, 0);
        Local_Reset = 1'b0;

        for (int i = 0; i < 8; i++) check_row(i);

        // Asynchronous reset in TRAIN at sample 1.
        @(negedge S_AXI_ACLK);
        bus.num_init_samples     = 1;
        bus.num_train_samples    = 3;
        bus.num_test_samples     = 1;
        bus.num_steps_per_sample = 2;
        bus.start                = 1'b1;
        bus.step_ack             = 1'b1;
        @(negedge S_AXI_ACLK);
        bus.start = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge S_AXI_ACLK);
            found = (bus.phase == 2 && bus.sample_idx == 1);
        end
        chk("rst_wait_train_s1", found, 1);
        #2 Local_Reset = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_phase", bus.phase, 0);
        chk("arst_req", bus.step_req, 0);
        chk("arst_sample_idx", bus.sample_idx, 0);
        chk("arst_step_idx", bus.step_idx, 0);
        chk("arst_done", bus.done, 0);
        @(negedge S_AXI_ACLK);
        Local_Reset  = 1'b0;
        bus.step_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge S_AXI_ACLK);
            chk("post_rst_done", bus.done, 0);
            chk("post_rst_busy", bus.busy, 0);
        end
        check_row(0);

        // Randomized configurations against the event-list model.
        for (int i = 0; i < 20; i++)
            run($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
